// File: rtl/alu_if.sv
// alu_if: operand/result handshake bundle for alu_pipe (master=upstream+downstream driver side, slave=alu)
interface alu_if #(parameter int BUS = 8);
  logic           in_valid;
  logic           in_ready;
  logic [BUS-1:0] a;
  logic [BUS-1:0] b;
  logic [3:0]     op_code;
  logic           out_valid;
  logic           out_ready;
  logic [BUS-1:0] y;
  logic [BUS-1:0] y_hi;
  logic           carry_out;
  logic           borrow;
  logic           overflow;
  logic           zero;
  logic           parity;
  logic           invalid_opcode;
  logic           busy;
  modport master (
    output in_valid, a, b, op_code, out_ready,
    input  in_ready, out_valid, y, y_hi, carry_out, borrow, overflow, zero, parity, invalid_opcode, busy
  );
  modport slave (
    input  in_valid, a, b, op_code, out_ready,
    output in_ready, out_valid, y, y_hi, carry_out, borrow, overflow, zero, parity, invalid_opcode, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with shift-add MUL; clk/rst plus alu_if.slave s (in_valid/in_ready/a/b/op_code in, out_valid/out_ready/y/y_hi/flags/busy out)
module alu_pipe #(
  parameter int BUS = 8
) (
  input logic clk,
  input logic rst,
  alu_if.slave s
);
  localparam int CW = $clog2(BUS);
  localparam logic [CW-1:0] LAST = CW'(BUS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [BUS-1:0]   ma;
  logic [2*BUS-1:0] p;
  logic [2*BUS-1:0] p_next;
  logic [BUS:0]     step;
  logic             c_flag;
  logic             ov_r, co_r, bo_r, of_r, inv_r;
  logic [BUS-1:0]   y_r, yh_r;
  logic [3:0]       op;
  logic             acc, is_add, is_sub;
  logic [BUS-1:0]   bb, r_y;
  logic [BUS:0]     add_r, sub_r;
  logic             r_c, r_b, r_o;
  assign op      = s.op_code;
  assign acc     = s.in_valid && s.in_ready;
  assign is_add  = op == 4'd1 || op == 4'd2 || op == 4'd4;
  assign is_sub  = op == 4'd3 || op == 4'd5;
  assign bb      = (op == 4'd4 || op == 4'd5) ? BUS'(1) : s.b;
  assign add_r   = {1'b0, s.a} + {1'b0, bb} + {{BUS{1'b0}}, op == 4'd2 && c_flag};
  assign sub_r   = {1'b0, s.a} - {1'b0, bb};
  assign r_c     = is_add && add_r[BUS];
  assign r_b     = is_sub && sub_r[BUS];
  assign r_o     = is_add ? (s.a[BUS-1] == bb[BUS-1]) && (add_r[BUS-1] != s.a[BUS-1]) :
                   is_sub ? (s.a[BUS-1] != bb[BUS-1]) && (sub_r[BUS-1] != s.a[BUS-1]) : 1'b0;
  assign r_y     = is_add ? add_r[BUS-1:0] :
                   is_sub ? sub_r[BUS-1:0] :
                   op == 4'd6 ? s.a & s.b :
                   op == 4'd7 ? ~s.a :
                   op == 4'd8 ? {s.a[BUS-2:0], s.a[BUS-1]} :
                   op == 4'd9 ? {s.a[0], s.a[BUS-1:1]} : '0;
  // product register holds {partial_hi, remaining multiplier}; each step adds and shifts right
  assign step    = {1'b0, p[2*BUS-1:BUS]} + (p[0] ? {1'b0, ma} : '0);
  assign p_next  = {step, p[BUS-1:1]};
  assign s.in_ready       = state == IDLE && (!ov_r || s.out_ready);
  assign s.busy           = state == MUL;
  assign s.out_valid      = ov_r;
  assign s.y              = y_r;
  assign s.y_hi           = yh_r;
  assign s.carry_out      = co_r;
  assign s.borrow         = bo_r;
  assign s.overflow       = of_r;
  assign s.invalid_opcode = inv_r;
  assign s.zero           = ~|{yh_r, y_r};
  assign s.parity         = ^y_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      ma     <= '0;
      p      <= '0;
      c_flag <= 1'b0;
      ov_r   <= 1'b0;
      y_r    <= '0;
      yh_r   <= '0;
      co_r   <= 1'b0;
      bo_r   <= 1'b0;
      of_r   <= 1'b0;
      inv_r  <= 1'b0;
    end else begin
      if (s.out_ready) ov_r <= 1'b0;
      if (acc && op == 4'd10) begin
        state <= MUL;
        count <= '0;
        ma    <= s.a;
        p     <= {{BUS{1'b0}}, s.b};
      end else if (acc) begin
        ov_r  <= 1'b1;
        y_r   <= r_y;
        yh_r  <= '0;
        co_r  <= r_c;
        bo_r  <= r_b;
        of_r  <= r_o;
        inv_r <= op == 4'd0 || op > 4'd11;
        if (is_add) c_flag <= r_c;
        else if (op == 4'd11) c_flag <= 1'b0;
      end else if (state == MUL) begin
        p     <= p_next;
        count <= count + 1'b1;
        if (count == LAST) begin
          state <= IDLE;
          ov_r  <= 1'b1;
          y_r   <= p_next[BUS-1:0];
          yh_r  <= p_next[2*BUS-1:BUS];
          co_r  <= 1'b0;
          bo_r  <= 1'b0;
          of_r  <= 1'b0;
          inv_r <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe with BUS=8
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int w;
  logic [22:0] obs;
  logic [22:0] e;
  alu_if #(.BUS(8)) bus ();
  alu_pipe #(.BUS(8)) dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  assign obs = {bus.out_valid, bus.y, bus.y_hi, bus.carry_out, bus.borrow, bus.overflow,
                bus.zero, bus.parity, bus.invalid_opcode};
  function automatic logic [22:0] ev(input logic ov, input logic [7:0] y, input logic [7:0] yh,
                                     input logic c, input logic bo, input logic o,
                                     input logic z, input logic p, input logic i);
    return {ov, y, yh, c, bo, o, z, p, i};
  endfunction
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int waited);
    bus.in_valid = 1'b1;
    bus.op_code  = op;
    bus.a        = a;
    bus.b        = b;
    waited       = 0;
    #1;
    while (!bus.in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout op=%0d got in_ready=0 want 1 within 40 cycles", op);
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_reset;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.op_code = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    e = ev(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL reset_outputs got %h want %h", obs, e); end
    n_vec++; if ({bus.in_ready, bus.busy} !== 2'b10) begin n_bad++; $display("FAIL reset_ready_busy got %b want 10", {bus.in_ready, bus.busy}); end
  endtask
  task automatic test_add_carry;
    issue(4'd1, 8'hFF, 8'h01, w);
    e = ev(1, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL add_ff_01 got %h want %h", obs, e); end
    issue(4'd2, 8'h00, 8'h00, w);
    e = ev(1, 8'h01, 8'h00, 0, 0, 0, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL addc_uses_carry got %h want %h", obs, e); end
  endtask
  task automatic test_back_to_back;
    issue(4'd1, 8'h7F, 8'h01, w);
    e = ev(1, 8'h80, 8'h00, 0, 0, 1, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL add_overflow got %h want %h", obs, e); end
    issue(4'd3, 8'h10, 8'h20, w);
    e = ev(1, 8'hF0, 8'h00, 0, 1, 0, 0, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL sub_borrow got %h want %h", obs, e); end
    n_vec++; if (w !== 0) begin n_bad++; $display("FAIL sub_back_to_back got wait=%0d want 0", w); end
    issue(4'd4, 8'hFF, 8'h00, w);
    e = ev(1, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL inc_wrap got %h want %h", obs, e); end
    issue(4'd5, 8'h80, 8'h00, w);
    e = ev(1, 8'h7F, 8'h00, 0, 0, 1, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL dec_overflow got %h want %h", obs, e); end
    issue(4'd5, 8'h00, 8'h00, w);
    e = ev(1, 8'hFF, 8'h00, 0, 1, 0, 0, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL dec_borrow got %h want %h", obs, e); end
    issue(4'd11, 8'h55, 8'hAA, w);
    e = ev(1, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL clc got %h want %h", obs, e); end
    issue(4'd2, 8'h00, 8'h00, w);
    e = ev(1, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL addc_after_clc got %h want %h", obs, e); end
  endtask
  task automatic test_logic;
    issue(4'd6, 8'hF3, 8'h3C, w);
    e = ev(1, 8'h30, 8'h00, 0, 0, 0, 0, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL and got %h want %h", obs, e); end
    issue(4'd7, 8'h0F, 8'h00, w);
    e = ev(1, 8'hF0, 8'h00, 0, 0, 0, 0, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL not got %h want %h", obs, e); end
    issue(4'd9, 8'h01, 8'h00, w);
    e = ev(1, 8'h80, 8'h00, 0, 0, 0, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL ror got %h want %h", obs, e); end
  endtask
  task automatic test_mul;
    issue(4'd10, 8'hFF, 8'hFF, w);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
        n_bad++; $display("FAIL mul_busy cycle %0d got busy/ready/valid=%b want 100", i, {bus.busy, bus.in_ready, bus.out_valid});
      end
      @(posedge clk); #1;
    end
    e = ev(1, 8'h01, 8'hFE, 0, 0, 0, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL mul_ff_ff got %h want %h", obs, e); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mul_done_busy got %b want 0", bus.busy); end
    issue(4'd1, 8'h01, 8'h02, w);
    e = ev(1, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL add_after_mul got %h want %h", obs, e); end
    n_vec++; if (w !== 0) begin n_bad++; $display("FAIL add_after_mul_wait got %0d want 0", w); end
    issue(4'd10, 8'h0D, 8'h0B, w);
    repeat (8) begin @(posedge clk); #1; end
    e = ev(1, 8'h8F, 8'h00, 0, 0, 0, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL mul_0d_0b got %h want %h", obs, e); end
  endtask
  task automatic test_backpressure;
    issue(4'd8, 8'h81, 8'h00, w);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op_code = 4'd6; bus.a = 8'hFF; bus.b = 8'h0F;
    #1;
    e = ev(1, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (obs !== e) begin n_bad++; $display("FAIL rol_hold cycle %0d got %h want %h", i, obs, e); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready cycle %0d got %b want 0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e = ev(1, 8'h0F, 8'h00, 0, 0, 0, 0, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL and_after_release got %h want %h", obs, e); end
  endtask
  task automatic test_mul_reset;
    logic stray;
    issue(4'd1, 8'hFF, 8'h01, w);
    e = ev(1, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL add_set_carry got %h want %h", obs, e); end
    issue(4'd10, 8'h12, 8'h34, w);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    e = ev(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL mid_mul_reset got %h want %h", obs, e); end
    n_vec++; if ({bus.in_ready, bus.busy} !== 2'b10) begin n_bad++; $display("FAIL mid_mul_reset_ready got %b want 10", {bus.in_ready, bus.busy}); end
    stray = 1'b0;
    repeat (12) begin @(posedge clk); #1; stray |= bus.out_valid; end
    n_vec++; if (stray !== 1'b0) begin n_bad++; $display("FAIL stray_result got %b want 0", stray); end
    issue(4'd2, 8'h00, 8'h00, w);
    e = ev(1, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL addc_after_reset got %h want %h", obs, e); end
  endtask
  task automatic test_invalid;
    logic [3:0] bad_ops [3];
    bad_ops = '{4'd0, 4'd15, 4'd12};
    issue(4'd2, 8'hFF, 8'h01, w);
    e = ev(1, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL addc_set_carry got %h want %h", obs, e); end
    e = ev(1, 8'h00, 8'h00, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      issue(bad_ops[i], 8'hA5, 8'h5A, w);
      n_vec++; if (obs !== e) begin n_bad++; $display("FAIL invalid_op_%0d got %h want %h", bad_ops[i], obs, e); end
    end
    issue(4'd2, 8'h00, 8'h00, w);
    e = ev(1, 8'h01, 8'h00, 0, 0, 0, 0, 1, 0);
    n_vec++; if (obs !== e) begin n_bad++; $display("FAIL carry_kept_over_invalid got %h want %h", obs, e); end
  endtask
  initial begin
    test_reset;
    test_add_carry;
    test_back_to_back;
    test_logic;
    test_mul;
    test_backpressure;
    test_mul_reset;
    test_invalid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Sequential, parametrised successor to the team's combinational ALU. It keeps the opcode map of opcodes 1..9 and adds a multi-cycle unsigned multiply, a stored carry flag and a signed-overflow flag. Operands enter and results leave through valid/ready handshakes, and all outputs are registered. It sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
BUS, 8, operand/result width in bits (>= 4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode present
in_ready  output  1  block can accept an operation this cycle
a  input  BUS  operand A
b  input  BUS  operand B
op_code  input  4  operation select
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  downstream consumes the result
y  output  BUS  result (low half for MUL)
y_hi  output  BUS  high half of MUL product; 0 for all other ops
carry_out  output  1  carry from ADD/ADDC/INC
borrow  output  1  borrow from SUB/DEC
overflow  output  1  signed (two's complement) overflow, ADD/ADDC/SUB/INC/DEC only
zero  output  1  ({y_hi,y} == 0)
parity  output  1  XOR reduction of y
invalid_opcode  output  1  accepted opcode was unsupported
busy  output  1  multiply in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Opcodes:
  - 1 ADD: a+b.
  - 2 ADDC: a+b+c_flag.
  - 3 SUB: a-b.
  - 4 INC: a+1.
  - 5 DEC: a-1.
  - 6 AND: a&b.
  - 7 NOT: ~a.
  - 8 ROL: rotate left by 1.
  - 9 ROR: rotate right by 1.
  - 10 MUL: unsigned a*b, giving {y_hi,y}.
  - 11 CLC: y=0 and c_flag cleared.
  - 0 and 12..15: invalid.
- Arithmetic is modulo 2^BUS. carry_out and borrow are bit BUS of the (BUS+1)-bit result. Flags not produced by an op are 0.
- Internal c_flag register: loaded with carry_out on ADD/ADDC/INC, cleared by CLC, unchanged by all other ops.
- zero and parity are derived from the registered y/y_hi and change only when the result registers load.
- Handshake:
  - Accept occurs at a rising edge when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid falls after an edge with out_valid && out_ready, unless a new result loads on that same edge. In that case out_valid stays 1.
  - While out_valid && !out_ready, y, y_hi and all flags are held stable.
- Latency:
  - Single-cycle ops (1-9, 11, invalid): results register on the accept edge, so out_valid is high the following cycle. Back-to-back accepts give one result per cycle.
  - MUL: an FSM does one shift-add step per clock and runs exactly BUS steps. The result registers load on the BUS-th edge after the accept edge.
- FSM states:
  - IDLE: accept MUL → MUL, with count=0, operands latched, accumulator cleared.
  - MUL: busy=1, in_ready=0, count++ each edge.
    - When count==BUS-1: load {y_hi,y}, set out_valid, return to IDLE.
    - The MUL state waits for IDLE only; the prior result must already be consumed because in_ready requires it at accept.
- Invalid opcode: accepted like a single-cycle op. y=0, y_hi=0, invalid_opcode=1, other flags 0, c_flag unchanged.
- Reset (any state, including mid-MUL):
  - Outputs: out_valid=0, busy=0, y=0, y_hi=0, carry_out=0, borrow=0, overflow=0, invalid_opcode=0, zero=1, parity=0.
  - Internal: c_flag=0, state=IDLE, count=0.
  - in_ready=1 in the first cycle after reset.
  - Any partial product is discarded, and no result is emitted for an aborted MUL.
- in_valid while in_ready=0: ignored. The upstream stage holds its inputs.

Test Plan:
- BUS=8. ADD a=0xFF b=0x01, then ADDC a=0x00 b=0x00 → first result y=0x00 carry_out=1 zero=1 overflow=0; second y=0x01 carry_out=0 (c_flag consumed).
- ADD a=0x7F b=0x01 → y=0x80 overflow=1 parity=1. Then SUB a=0x10 b=0x20 → y=0xF0 borrow=1 overflow=0. Results on consecutive cycles with out_ready=1 throughout.
- MUL a=0xFF b=0xFF → in_ready=0 and busy=1 for 8 cycles, then y=0x01 y_hi=0xFE zero=0. Next op accepted the cycle after out_valid with out_ready=1.
- Backpressure: out_ready=0 after ROL a=0x81 → y=0x03 held, out_valid=1 and in_ready=0 for 5 cycles. Raise out_ready → in_ready=1 in the same cycle, new op accepted, out_valid stays 1.
- Reset asserted 3 cycles into MUL a=0x12 b=0x34 → next cycle out_valid=0, busy=0, in_ready=1, zero=1, and no stray result afterwards. CLC/c_flag=0 verified by ADDC 0+0 → y=0x00.
- op_code=0 and op_code=15 → invalid_opcode=1 y=0 zero=1. A preceding ADDC's c_flag=1 is preserved, shown by a following ADDC 0+0 → y=0x01.
